// File: rtl/irq_pkg.sv
// Shared types and constants for the 4-line interrupt controller.
package irq_pkg;

  // Number of request lines handled by the controller.
  localparam int NUM_IRQ = 4;

  // Default synchroniser depth; legal range is 2..4.
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Index of a request line; 3 is the highest priority.
  typedef logic [1:0] irq_code_t;

  // Handshake state: IDLE looks for work, PRESENT holds a code until accepted.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

  // One-hot mask selecting the pending bit that belongs to a code.
  function automatic logic [NUM_IRQ-1:0] code_onehot(input irq_code_t code);
    logic [NUM_IRQ-1:0] oh;
    oh = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// Single-bit synchroniser with a history flop that emits a one-cycle pulse
// when the synchronised input goes from 0 to 1.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  output logic edge_o
);

  // sync_q[0] samples the asynchronous line; the top stage is the clean copy.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw request through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
    end
  end

  // Remember last cycle's synchronised level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_out;
    end
  end

  // Pulse is combinational so pending can be set on the very next edge.
  assign edge_o = sync_out & ~prev_q;

endmodule : irq_sync_edge

// File: rtl/irq_ctrl4.sv
// Four-line interrupt controller: edge capture into pending, masking,
// fixed priority (bit 3 highest) and a valid/ready presentation FSM.
module irq_ctrl4
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  output logic       irq_valid,
  output logic [1:0] irq_code,
  input  logic       irq_ready,
  output logic [3:0] pending,
  output logic [3:0] lost,
  input  logic       lost_clr
);

  logic [NUM_IRQ-1:0] edge_w;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] lost_q, lost_d;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] clear_mask;
  logic [NUM_IRQ-1:0] lost_set;
  irq_code_t          req_code;
  logic               has_req;
  irq_code_t          code_q;
  irq_state_t         state_q, state_d;
  logic               accept;
  logic               load_code;

  // One synchroniser/edge detector per request line.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .irq_i (irq_in[gi]),
      .edge_o(edge_w[gi])
    );
  end

  // Only unmasked pending bits compete for presentation.
  assign req = pending_q & ~mask;

  // Fixed-priority encode of the competing requests, bit 3 wins.
  always_comb begin
    req_code = 2'd0;
    has_req  = 1'b1;
    casez (req)
      4'b1???: req_code = 2'd3;
      4'b01??: req_code = 2'd2;
      4'b001?: req_code = 2'd1;
      4'b0001: req_code = 2'd0;
      default: begin
        req_code = 2'd0;
        has_req  = 1'b0;
      end
    endcase
  end

  // Pending/lost next state: a fresh edge beats the acceptance clear, and a
  // fresh lost event beats lost_clr.
  always_comb begin
    clear_mask = accept ? code_onehot(code_q) : '0;
    lost_set   = edge_w & pending_q & ~clear_mask;
    pending_d  = (pending_q & ~clear_mask) | edge_w;
    lost_d     = (lost_clr ? '0 : lost_q) | lost_set;
  end

  // Pending and lost registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      lost_q    <= '0;
    end else begin
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: grab a request in IDLE, release it on acceptance; the
  // forced return to IDLE spaces grants two cycles apart.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (has_req)   state_d = PRESENT;
      PRESENT: if (irq_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: valid is the PRESENT state itself, so it never retracts.
  always_comb begin
    irq_valid = (state_q == PRESENT);
    accept    = (state_q == PRESENT) && irq_ready;
    load_code = (state_q == IDLE) && has_req;
  end

  // Code is captured only at grant time and held through PRESENT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 2'd0;
    end else if (load_code) begin
      code_q <= req_code;
    end
  end

  assign irq_code = code_q;
  assign pending  = pending_q;
  assign lost     = lost_q;

endmodule : irq_ctrl4

// File: tb/tb_irq_ctrl4.sv
// Directed bench for irq_ctrl4 with hand-computed expectations.
module tb_irq_ctrl4;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_in;
  logic [3:0] mask;
  logic       irq_valid;
  logic [1:0] irq_code;
  logic       irq_ready;
  logic [3:0] pending;
  logic [3:0] lost;
  logic       lost_clr;

  int tests_run;
  int tests_failed;

  irq_ctrl4 #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask     (mask),
    .irq_valid(irq_valid),
    .irq_code (irq_code),
    .irq_ready(irq_ready),
    .pending  (pending),
    .lost     (lost),
    .lost_clr (lost_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    irq_in    = 4'b0;
    mask      = 4'b0;
    irq_ready = 1'b0;
    lost_clr  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    irq_in    = 4'hF;
    mask      = 4'b0;
    irq_ready = 1'b0;
    lost_clr  = 1'b0;

    // T1: reset with all lines high, then latency after release.
    repeat (2) step();
    check("t1_rst_valid", irq_valid, 1'b0);
    check("t1_rst_code", irq_code, 2'd0);
    check("t1_rst_pending", pending, 4'h0);
    check("t1_rst_lost", lost, 4'h0);
    rst_n = 1'b1;
    step();
    check("t1_e1_pending", pending, 4'h0);
    step();
    check("t1_e2_pending", pending, 4'h0);
    step();
    check("t1_e3_pending", pending, 4'hF);
    check("t1_e3_valid", irq_valid, 1'b0);
    step();
    check("t1_e4_valid", irq_valid, 1'b1);
    check("t1_e4_code", irq_code, 2'd3);

    // T2: two pending lines granted two cycles apart.
    do_reset();
    mask   = 4'hF;
    irq_in = 4'b0101;
    repeat (4) step();
    irq_in = 4'b0;
    repeat (4) step();
    check("t2_pending", pending, 4'b0101);
    check("t2_masked_valid", irq_valid, 1'b0);
    mask      = 4'h0;
    irq_ready = 1'b1;
    step();
    check("t2_g1_valid", irq_valid, 1'b1);
    check("t2_g1_code", irq_code, 2'd2);
    step();
    check("t2_acc1_valid", irq_valid, 1'b0);
    check("t2_acc1_pending", pending, 4'b0001);
    step();
    check("t2_g2_valid", irq_valid, 1'b1);
    check("t2_g2_code", irq_code, 2'd0);
    step();
    check("t2_acc2_valid", irq_valid, 1'b0);
    check("t2_acc2_pending", pending, 4'b0000);
    irq_ready = 1'b0;

    // T3: masked line pends silently, unmask presents it next cycle.
    do_reset();
    mask   = 4'b1000;
    irq_in = 4'b1000;
    repeat (5) step();
    check("t3_pending", pending, 4'b1000);
    check("t3_masked_valid", irq_valid, 1'b0);
    mask = 4'b0000;
    step();
    check("t3_unmask_valid", irq_valid, 1'b1);
    check("t3_unmask_code", irq_code, 2'd3);
    irq_ready = 1'b1;
    step();
    check("t3_acc_valid", irq_valid, 1'b0);
    check("t3_acc_pending", pending, 4'b0000);
    irq_ready = 1'b0;
    irq_in    = 4'b0;

    // T4: stall with mask rising on the presented line; no retraction.
    do_reset();
    irq_in = 4'b0010;
    repeat (4) step();
    check("t4_valid", irq_valid, 1'b1);
    check("t4_code", irq_code, 2'd1);
    mask = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_valid", irq_valid, 1'b1);
      check("t4_hold_code", irq_code, 2'd1);
    end
    irq_ready = 1'b1;
    step();
    check("t4_acc_valid", irq_valid, 1'b0);
    check("t4_acc_pending", pending, 4'b0000);
    irq_ready = 1'b0;
    irq_in    = 4'b0;

    // T5: lost capture, lost clear, and an edge landing on the acceptance.
    do_reset();
    mask   = 4'hF;
    irq_in = 4'b0100;
    repeat (4) step();
    irq_in = 4'b0;
    repeat (3) step();
    check("t5_pending", pending, 4'b0100);
    check("t5_lost0", lost, 4'b0000);
    irq_in = 4'b0100;
    repeat (3) step();
    check("t5_lost_set", lost, 4'b0100);
    check("t5_pending_kept", pending, 4'b0100);
    irq_in   = 4'b0;
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    check("t5_lost_clr", lost, 4'b0000);
    repeat (3) step();
    mask = 4'h0;
    step();
    check("t5_present_valid", irq_valid, 1'b1);
    check("t5_present_code", irq_code, 2'd2);
    irq_in = 4'b0100;
    repeat (2) step();
    irq_ready = 1'b1;
    step();
    check("t5_race_valid", irq_valid, 1'b0);
    check("t5_race_pending", pending, 4'b0100);
    check("t5_race_lost", lost, 4'b0000);
    irq_ready = 1'b0;
    step();
    check("t5_repend_valid", irq_valid, 1'b1);
    check("t5_repend_code", irq_code, 2'd2);
    irq_ready = 1'b1;
    step();
    check("t5_final_pending", pending, 4'b0000);
    irq_ready = 1'b0;
    irq_in    = 4'b0;

    // T6: asynchronous reset mid-PRESENT drops valid without a clock edge.
    do_reset();
    irq_in = 4'b0001;
    repeat (4) step();
    check("t6_valid", irq_valid, 1'b1);
    check("t6_code", irq_code, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", irq_valid, 1'b0);
    check("t6_async_pending", pending, 4'b0000);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_irq_ctrl4
